// File: rtl/axi_ax_arb_mux_pkg.sv
// Shared types and default widths for the AXI address-channel arbiter/mux.
// Also holds the round-robin pointer wrap helper.
package axi_ax_arb_mux_pkg;

   localparam int unsigned AXI_ID_BITS   = 4;
   localparam int unsigned AXI_MID_BITS  = 4;
   localparam int unsigned AXI_ADDR_BITS = 32;
   localparam int unsigned AXI_LEN_BITS  = 4;
   localparam int unsigned AXI_SIZE_BITS = 3;

   typedef enum logic [1:0] {
      BurstFixed = 2'd0,
      BurstIncr  = 2'd1,
      BurstWrap  = 2'd2
   } burst_t;

   typedef struct packed {
      logic [AXI_ID_BITS-1:0]   id;
      logic [AXI_ADDR_BITS-1:0] addr;
      logic [AXI_LEN_BITS-1:0]  len;
      logic [AXI_SIZE_BITS-1:0] size;
      burst_t                   burst;
   } ax_req_t;

   // Next round-robin start index; wraps for non-power-of-2 counts.
   function automatic int unsigned wrap_inc(int unsigned idx, int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/axi_ax_arb_mux_if.sv
// AXI address-channel bundle carrying N lanes side by side (lane i at [i*W +: W]).
// master drives request/payload, slave drives ready.
interface axi_ax_arb_mux_if #(
   parameter int unsigned N      = 1,
   parameter int unsigned ID_W   = 4,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned LEN_W  = 4,
   parameter int unsigned SIZE_W = 3
);
   logic [N*ID_W-1:0]   AxID;
   logic [N*ADDR_W-1:0] AxADDR;
   logic [N*LEN_W-1:0]  AxLEN;
   logic [N*SIZE_W-1:0] AxSIZE;
   logic [N*2-1:0]      AxBURST;
   logic [N-1:0]        AxVALID;
   logic [N-1:0]        AxREADY;

   modport master (
      output AxID, AxADDR, AxLEN, AxSIZE, AxBURST, AxVALID,
      input  AxREADY
   );

   modport slave (
      input  AxID, AxADDR, AxLEN, AxSIZE, AxBURST, AxVALID,
      output AxREADY
   );
endinterface

// File: rtl/axi_ax_arb_mux_rr_arbiter.sv
// Round-robin / fixed-priority arbiter producing a one-hot grant and its index.
// The round-robin pointer lives here and advances past the winner when upd is set.
module axi_ax_arb_mux_rr_arbiter
   import axi_ax_arb_mux_pkg::*;
#(
   parameter int unsigned N     = 2,
   parameter bit          RR_EN = 1'b1,
   parameter int unsigned IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   input  logic             upd,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             any
);

   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [N-1:0]     req_hi;

   // Requests at or above the pointer are searched first, then the wrapped remainder.
   always_comb begin
      req_hi = '0;
      for (int unsigned i = 0; i < N; i++) begin
         req_hi[i] = req[i] && RR_EN && (IDX_W'(i) >= ptr_q);
      end
   end

   always_comb begin
      gnt_idx = '0;
      any     = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!any && req_hi[i]) begin
            any     = 1'b1;
            gnt_idx = IDX_W'(i);
         end
      end
      for (int unsigned i = 0; i < N; i++) begin
         if (!any && req[i]) begin
            any     = 1'b1;
            gnt_idx = IDX_W'(i);
         end
      end
      gnt = '0;
      for (int unsigned i = 0; i < N; i++) begin
         gnt[i] = any && (gnt_idx == IDX_W'(i));
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (RR_EN && upd && any) begin
         ptr_d = IDX_W'(wrap_inc(32'(gnt_idx), N));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/axi_ax_arb_mux.sv
// N-to-1 AXI address-channel arbiter and mux with a one-entry registered output stage.
// The winning master index is prefixed onto the forwarded ID.
module axi_ax_arb_mux
   import axi_ax_arb_mux_pkg::*;
#(
   parameter int unsigned NUM_M  = 2,
   parameter int unsigned ID_W   = AXI_ID_BITS,
   parameter int unsigned MID_W  = AXI_MID_BITS,
   parameter int unsigned ADDR_W = AXI_ADDR_BITS,
   parameter int unsigned LEN_W  = AXI_LEN_BITS,
   parameter int unsigned SIZE_W = AXI_SIZE_BITS,
   parameter bit          RR_EN  = 1'b1
) (
   input  logic             ACLK,
   input  logic             ARESETn,
   axi_ax_arb_mux_if.slave  up,
   axi_ax_arb_mux_if.master dn,
   output logic [MID_W-1:0] gnt_idx
);

   logic              can_load, any;
   logic [NUM_M-1:0]  req, gnt;
   logic [MID_W-1:0]  win_idx;
   logic [ID_W-1:0]   id_mux;
   logic [ADDR_W-1:0] addr_mux;
   logic [LEN_W-1:0]  len_mux;
   logic [SIZE_W-1:0] size_mux;
   logic [1:0]        burst_mux;

   logic                  valid_q, valid_d;
   logic [MID_W+ID_W-1:0] id_q, id_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [LEN_W-1:0]      len_q, len_d;
   logic [SIZE_W-1:0]     size_q, size_d;
   logic [1:0]            burst_q, burst_d;

   // Nothing is accepted while reset is asserted, so no master handshake can be lost.
   assign can_load = ARESETn && (!valid_q || dn.AxREADY[0]);
   assign req      = up.AxVALID & {NUM_M{can_load}};

   axi_ax_arb_mux_rr_arbiter #(
      .N     (NUM_M),
      .RR_EN (RR_EN),
      .IDX_W (MID_W)
   ) u_arb (
      .clk     (ACLK),
      .rst_n   (ARESETn),
      .req     (req),
      .upd     (can_load),
      .gnt     (gnt),
      .gnt_idx (win_idx),
      .any     (any)
   );

   assign up.AxREADY = gnt;
   assign gnt_idx    = win_idx;

   always_comb begin
      id_mux    = '0;
      addr_mux  = '0;
      len_mux   = '0;
      size_mux  = '0;
      burst_mux = '0;
      for (int unsigned i = 0; i < NUM_M; i++) begin
         if (win_idx == MID_W'(i)) begin
            id_mux    = up.AxID[i*ID_W +: ID_W];
            addr_mux  = up.AxADDR[i*ADDR_W +: ADDR_W];
            len_mux   = up.AxLEN[i*LEN_W +: LEN_W];
            size_mux  = up.AxSIZE[i*SIZE_W +: SIZE_W];
            burst_mux = up.AxBURST[i*2 +: 2];
         end
      end
   end

   // A new winner overwrites the slot in the same edge it drains: no bubble.
   always_comb begin
      valid_d = valid_q;
      id_d    = id_q;
      addr_d  = addr_q;
      len_d   = len_q;
      size_d  = size_q;
      burst_d = burst_q;
      if (any) begin
         valid_d = 1'b1;
         id_d    = {win_idx, id_mux};
         addr_d  = addr_mux;
         len_d   = len_mux;
         size_d  = size_mux;
         burst_d = burst_mux;
      end else if (dn.AxREADY[0]) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         valid_q <= 1'b0;
         id_q    <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         size_q  <= '0;
         burst_q <= '0;
      end else begin
         valid_q <= valid_d;
         id_q    <= id_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         size_q  <= size_d;
         burst_q <= burst_d;
      end
   end

   assign dn.AxVALID = valid_q;
   assign dn.AxID    = id_q;
   assign dn.AxADDR  = addr_q;
   assign dn.AxLEN   = len_q;
   assign dn.AxSIZE  = size_q;
   assign dn.AxBURST = burst_q;

endmodule

// File: tb/tb_axi_ax_arb_mux.sv
// Directed bench for axi_ax_arb_mux: 2-master round-robin instance for handshake,
// stall, drop and reset cases; 3-master round-robin and fixed-priority instances for ordering.
module tb_axi_ax_arb_mux;
   import axi_ax_arb_mux_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   axi_ax_arb_mux_if #(.N(2), .ID_W(4)) up_a ();
   axi_ax_arb_mux_if #(.N(1), .ID_W(8)) dn_a ();
   axi_ax_arb_mux_if #(.N(3), .ID_W(4)) up_b ();
   axi_ax_arb_mux_if #(.N(1), .ID_W(8)) dn_b ();
   axi_ax_arb_mux_if #(.N(3), .ID_W(4)) up_c ();
   axi_ax_arb_mux_if #(.N(1), .ID_W(8)) dn_c ();
   logic [3:0] gnt_a, gnt_b, gnt_c;

   axi_ax_arb_mux #(.NUM_M(2), .RR_EN(1'b1)) u_dut_a (
      .ACLK(clk), .ARESETn(rst_n), .up(up_a), .dn(dn_a), .gnt_idx(gnt_a));
   axi_ax_arb_mux #(.NUM_M(3), .RR_EN(1'b1)) u_dut_b (
      .ACLK(clk), .ARESETn(rst_n), .up(up_b), .dn(dn_b), .gnt_idx(gnt_b));
   axi_ax_arb_mux #(.NUM_M(3), .RR_EN(1'b0)) u_dut_c (
      .ACLK(clk), .ARESETn(rst_n), .up(up_c), .dn(dn_c), .gnt_idx(gnt_c));

   // Fixed-priority instance sees exactly the same stimulus as the round-robin one.
   assign up_c.AxID    = up_b.AxID;
   assign up_c.AxADDR  = up_b.AxADDR;
   assign up_c.AxLEN   = up_b.AxLEN;
   assign up_c.AxSIZE  = up_b.AxSIZE;
   assign up_c.AxBURST = up_b.AxBURST;
   assign up_c.AxVALID = up_b.AxVALID;
   assign dn_c.AxREADY = dn_b.AxREADY;

   logic [1:0] exp_t2_rdy [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
   logic [7:0] exp_t2_id  [4] = '{8'h0A, 8'h1B, 8'h0A, 8'h1B};
   logic [2:0] exp_rr_rdy [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
   logic [7:0] exp_rr_id  [4] = '{8'h01, 8'h12, 8'h23, 8'h01};
   logic [3:0] exp_rr_gnt [4] = '{4'd0, 4'd1, 4'd2, 4'd0};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_a(input logic [1:0] v, input logic [3:0] id0, input logic [3:0] id1,
                        input logic [31:0] a0, input logic [31:0] a1);
      up_a.AxVALID = v;
      up_a.AxID    = {id1, id0};
      up_a.AxADDR  = {a1, a0};
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      set_a(2'b00, 4'h0, 4'h0, 32'h0, 32'h0);
      up_a.AxLEN   = {4'd3, 4'd3};
      up_a.AxSIZE  = {3'd2, 3'd2};
      up_a.AxBURST = {BurstIncr, BurstIncr};
      dn_a.AxREADY = 1'b1;
      up_b.AxVALID = 3'b000;
      up_b.AxID    = {4'h3, 4'h2, 4'h1};
      up_b.AxADDR  = {32'h300, 32'h200, 32'h100};
      up_b.AxLEN   = '0;
      up_b.AxSIZE  = '0;
      up_b.AxBURST = {BurstIncr, BurstIncr, BurstIncr};
      dn_b.AxREADY = 1'b1;

      // Reset state
      tick();
      check("rst_valid", 64'(dn_a.AxVALID), 64'd0);
      check("rst_ready", 64'(up_a.AxREADY), 64'd0);
      check("rst_id", 64'(dn_a.AxID), 64'd0);
      check("rst_addr", 64'(dn_a.AxADDR), 64'd0);
      check("rst_gnt", 64'(gnt_a), 64'd0);
      tick();
      rst_n = 1'b1;

      // 1: single request, one-cycle latency
      set_a(2'b01, 4'h3, 4'h0, 32'h1000, 32'h0);
      @(negedge clk);
      check("t1_ready", 64'(up_a.AxREADY), 64'b01);
      check("t1_gnt", 64'(gnt_a), 64'd0);
      check("t1_valid_pre", 64'(dn_a.AxVALID), 64'd0);
      tick();
      set_a(2'b00, 4'h0, 4'h0, 32'h0, 32'h0);
      check("t1_valid", 64'(dn_a.AxVALID), 64'd1);
      check("t1_id", 64'(dn_a.AxID), 64'h03);
      check("t1_addr", 64'(dn_a.AxADDR), 64'h1000);
      check("t1_len", 64'(dn_a.AxLEN), 64'd3);
      check("t1_burst", 64'(dn_a.AxBURST), 64'(BurstIncr));
      tick();
      check("t1_drain", 64'(dn_a.AxVALID), 64'd0);
      check("t1_hold", 64'(dn_a.AxADDR), 64'h1000);

      // 2: alternating grants from a fresh pointer
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      set_a(2'b11, 4'hA, 4'hB, 32'h100, 32'h200);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("t2_ready", 64'(up_a.AxREADY), 64'(exp_t2_rdy[k]));
         tick();
         check("t2_id", 64'(dn_a.AxID), 64'(exp_t2_id[k]));
         check("t2_valid", 64'(dn_a.AxVALID), 64'd1);
      end

      // 4: stall for 5 cycles, then drain+load in one edge
      dn_a.AxREADY = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("t4_ready", 64'(up_a.AxREADY), 64'b00);
         check("t4_id", 64'(dn_a.AxID), 64'h1B);
         check("t4_addr", 64'(dn_a.AxADDR), 64'h200);
         check("t4_valid", 64'(dn_a.AxVALID), 64'd1);
         tick();
      end
      dn_a.AxREADY = 1'b1;
      @(negedge clk);
      check("t4_rel_ready", 64'(up_a.AxREADY), 64'b01);
      tick();
      check("t4_nobubble", 64'(dn_a.AxVALID), 64'd1);
      check("t4_load_id", 64'(dn_a.AxID), 64'h0A);
      set_a(2'b00, 4'h0, 4'h0, 32'h0, 32'h0);
      tick();
      check("t4_empty", 64'(dn_a.AxVALID), 64'd0);

      // 5: master 1 prefix, then a request withdrawn while stalled
      set_a(2'b10, 4'h0, 4'hF, 32'h0, 32'h2000);
      @(negedge clk);
      check("t5_ready", 64'(up_a.AxREADY), 64'b10);
      check("t5_gnt", 64'(gnt_a), 64'd1);
      tick();
      check("t5_id", 64'(dn_a.AxID), 64'h1F);
      check("t5_addr", 64'(dn_a.AxADDR), 64'h2000);
      dn_a.AxREADY = 1'b0;
      set_a(2'b10, 4'h0, 4'hF, 32'h0, 32'h3000);
      @(negedge clk);
      check("t5_stall_ready", 64'(up_a.AxREADY), 64'b00);
      tick();
      set_a(2'b00, 4'h0, 4'h0, 32'h0, 32'h0);
      dn_a.AxREADY = 1'b1;
      @(negedge clk);
      check("t5_drop_ready", 64'(up_a.AxREADY), 64'b00);
      tick();
      check("t5_novalid", 64'(dn_a.AxVALID), 64'd0);
      check("t5_addr_hold", 64'(dn_a.AxADDR), 64'h2000);

      // 6: async reset during a stall clears output and pointer
      set_a(2'b01, 4'h1, 4'h0, 32'h4000, 32'h0);
      dn_a.AxREADY = 1'b0;
      @(negedge clk);
      check("t6_ready", 64'(up_a.AxREADY), 64'b01);
      tick();
      set_a(2'b11, 4'h1, 4'h2, 32'h4000, 32'h5000);
      check("t6_valid", 64'(dn_a.AxVALID), 64'd1);
      tick();
      #1;
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", 64'(dn_a.AxVALID), 64'd0);
      check("t6_rst_addr", 64'(dn_a.AxADDR), 64'd0);
      check("t6_rst_ready", 64'(up_a.AxREADY), 64'b00);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      dn_a.AxREADY = 1'b1;
      #1;
      check("t6_ptr", 64'(up_a.AxREADY), 64'b01);
      tick();
      set_a(2'b00, 4'h0, 4'h0, 32'h0, 32'h0);

      // 3: three masters, round-robin wrap versus fixed priority
      up_b.AxVALID = 3'b111;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("t3_rr_ready", 64'(up_b.AxREADY), 64'(exp_rr_rdy[k]));
         check("t3_rr_gnt", 64'(gnt_b), 64'(exp_rr_gnt[k]));
         check("t3_fp_ready", 64'(up_c.AxREADY), 64'b001);
         check("t3_fp_gnt", 64'(gnt_c), 64'd0);
         tick();
         check("t3_rr_id", 64'(dn_b.AxID), 64'(exp_rr_id[k]));
         check("t3_fp_id", 64'(dn_c.AxID), 64'h01);
      end
      up_b.AxVALID = 3'b000;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
